// File: rtl/hpdcache_pkg.sv
// Shared HPDcache types.
// Serializer beat-count type used by producers that build wlen_i.
package hpdcache_pkg;

    localparam int unsigned HPDCACHE_SER_RATIO = 4;

    typedef logic [$clog2(HPDCACHE_SER_RATIO)-1:0] hpdcache_ser_len_t;

endpackage

// File: rtl/hpdcache_mux.sv
// Generic N-input multiplexer with a binary select.
// Used for beat selection out of a latched wide word.
module hpdcache_mux #(
    parameter int unsigned N_INPUTS   = 2,
    parameter int unsigned DATA_WIDTH = 1,
    localparam int unsigned SEL_WIDTH = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic [SEL_WIDTH-1:0]                 sel_i,
    input  logic [N_INPUTS-1:0][DATA_WIDTH-1:0]  data_i,
    output logic [DATA_WIDTH-1:0]                data_o
);

    assign data_o = data_i[sel_i];

endmodule

// File: rtl/hpdcache_beat_serializer.sv
// Wide-to-narrow beat serializer: one wide word in (w/wok),
// a sequence of narrow beats with a last flag out (r/rok).
module hpdcache_beat_serializer
    import hpdcache_pkg::*;
#(
    parameter int unsigned NARROW_WIDTH = 64,
    parameter int unsigned RATIO        = 4,
    localparam int unsigned LEN_WIDTH   = $clog2(RATIO)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          w_i,
    output logic                          wok_o,
    input  logic [NARROW_WIDTH*RATIO-1:0] wdata_i,
    input  logic [LEN_WIDTH-1:0]          wlen_i,
    input  logic                          r_i,
    output logic                          rok_o,
    output logic [NARROW_WIDTH-1:0]       rdata_o,
    output logic                          rlast_o
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                               r_state;
    state_e                               w_state_d;
    logic [LEN_WIDTH-1:0]                 r_cnt;
    logic [LEN_WIDTH-1:0]                 w_cnt_d;
    logic [LEN_WIDTH-1:0]                 r_len;
    logic [RATIO-1:0][NARROW_WIDTH-1:0]   r_data;
    logic [NARROW_WIDTH-1:0]              w_beat;
    logic                                 w_busy;
    logic                                 w_last;
    logic                                 w_wok;
    logic                                 w_load;

    assign w_busy = (r_state == BUSY);
    assign w_last = w_busy && (r_cnt == r_len);
    // wok depends on r_i so a new word can follow the last beat without a bubble
    assign w_wok  = !w_busy || (w_last && r_i);
    assign w_load = w_i && w_wok;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_d = BUSY;
                    w_cnt_d   = '0;
                end
            end
            BUSY: begin
                if (r_i) begin
                    if (!w_last) begin
                        w_cnt_d = r_cnt + 1'b1;
                    end else if (w_i) begin
                        w_cnt_d = '0;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_load) begin
                r_data <= wdata_i;
                r_len  <= wlen_i;
            end
        end
    end

    hpdcache_mux #(
        .N_INPUTS   (RATIO),
        .DATA_WIDTH (NARROW_WIDTH)
    ) i_beat_mux (
        .sel_i  (r_cnt),
        .data_i (r_data),
        .data_o (w_beat)
    );

    assign wok_o   = w_wok;
    assign rok_o   = w_busy;
    assign rlast_o = w_last;
    assign rdata_o = w_busy ? w_beat : '0;

`ifndef SYNTHESIS
    a_wlen_known: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        w_i |-> !$isunknown(wlen_i));

    a_hold: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (rok_o && !r_i) |=> ($stable(rdata_o) && $stable(rlast_o)));
`endif

endmodule

// File: tb/tb_hpdcache_beat_serializer.sv
// Directed bench for hpdcache_beat_serializer.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_hpdcache_beat_serializer;

    logic         clk;
    logic         rst_n;
    logic         w;
    logic         wok;
    logic [255:0] wdata;
    logic [1:0]   wlen;
    logic         r;
    logic         rok;
    logic [63:0]  rdata;
    logic         rlast;

    int total = 0;
    int bad   = 0;

    hpdcache_beat_serializer #(
        .NARROW_WIDTH (64),
        .RATIO        (4)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .w_i     (w),
        .wok_o   (wok),
        .wdata_i (wdata),
        .wlen_i  (wlen),
        .r_i     (r),
        .rok_o   (rok),
        .rdata_o (rdata),
        .rlast_o (rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] bp_beats [4];
    int          idx;
    int          cyc;

    initial begin
        rst_n = 1'b0;
        w     = 1'b0;
        wdata = '0;
        wlen  = '0;
        r     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // reset state held for 10 cycles with no traffic
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("rst_wok", 64'(wok), 64'd1);
            chk("rst_rok", 64'(rok), 64'd0);
            chk("rst_rdata", rdata, 64'd0);
            chk("rst_rlast", 64'(rlast), 64'd0);
            tick();
        end

        // four beats, continuous r
        w     = 1'b1;
        wdata = {64'hD, 64'hC, 64'hB, 64'hA};
        wlen  = 2'd3;
        r     = 1'b1;
        #1;
        chk("t1_wok_idle", 64'(wok), 64'd1);
        chk("t1_rok_idle", 64'(rok), 64'd0);
        tick();
        w     = 1'b0;
        wdata = '1;
        #1;
        chk("t1_b0", rdata, 64'hA);
        chk("t1_l0", 64'(rlast), 64'd0);
        chk("t1_k0", 64'(rok), 64'd1);
        tick();
        chk("t1_b1", rdata, 64'hB);
        chk("t1_l1", 64'(rlast), 64'd0);
        tick();
        chk("t1_b2", rdata, 64'hC);
        chk("t1_l2", 64'(rlast), 64'd0);
        tick();
        chk("t1_b3", rdata, 64'hD);
        chk("t1_l3", 64'(rlast), 64'd1);
        chk("t1_k3", 64'(rok), 64'd1);
        tick();
        chk("t1_rok_end", 64'(rok), 64'd0);

        // back-to-back: 2-beat word then 1-beat word, w held
        w     = 1'b1;
        wdata = {64'h0, 64'h0, 64'hA1, 64'hA0};
        wlen  = 2'd1;
        r     = 1'b1;
        tick();
        wdata = {64'h0, 64'h0, 64'h0, 64'hB0};
        wlen  = 2'd0;
        #1;
        chk("bb_a0", rdata, 64'hA0);
        chk("bb_a0_last", 64'(rlast), 64'd0);
        chk("bb_a0_wok", 64'(wok), 64'd0);
        tick();
        chk("bb_a1", rdata, 64'hA1);
        chk("bb_a1_last", 64'(rlast), 64'd1);
        chk("bb_a1_wok", 64'(wok), 64'd1);
        tick();
        w = 1'b0;
        #1;
        chk("bb_b0", rdata, 64'hB0);
        chk("bb_b0_last", 64'(rlast), 64'd1);
        chk("bb_b0_rok", 64'(rok), 64'd1);
        tick();
        chk("bb_rok_end", 64'(rok), 64'd0);

        // backpressure: r = 1,0,0,1,0,0,...
        bp_beats[0] = 64'h11;
        bp_beats[1] = 64'h22;
        bp_beats[2] = 64'h33;
        bp_beats[3] = 64'h44;
        w     = 1'b1;
        wdata = {64'h44, 64'h33, 64'h22, 64'h11};
        wlen  = 2'd3;
        r     = 1'b0;
        tick();
        w     = 1'b0;
        wdata = {64'h99, 64'h88, 64'h77, 64'h66};
        wlen  = 2'd0;
        idx   = 0;
        cyc   = 0;
        while (idx < 4 && cyc < 20) begin
            r = (cyc % 3 == 0);
            #1;
            chk("bp_rok", 64'(rok), 64'd1);
            chk("bp_data", rdata, bp_beats[idx]);
            chk("bp_last", 64'(rlast), 64'(idx == 3));
            chk("bp_wok", 64'(wok), 64'(idx == 3 && r));
            if (r) idx++;
            cyc++;
            tick();
        end
        chk("bp_all_beats", 64'(idx), 64'd4);
        r = 1'b0;
        #1;
        chk("bp_rok_end", 64'(rok), 64'd0);

        // single beat held under r = 0, second word waits
        w     = 1'b1;
        wdata = {64'h0, 64'h0, 64'h0, 64'h55};
        wlen  = 2'd0;
        tick();
        wdata = {64'h0, 64'h0, 64'h0, 64'h66};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s1_rok", 64'(rok), 64'd1);
            chk("s1_last", 64'(rlast), 64'd1);
            chk("s1_data", rdata, 64'h55);
            chk("s1_wok", 64'(wok), 64'd0);
            tick();
        end
        r = 1'b1;
        #1;
        chk("s1_rel_wok", 64'(wok), 64'd1);
        chk("s1_rel_data", rdata, 64'h55);
        tick();
        w = 1'b0;
        #1;
        chk("s1_next_data", rdata, 64'h66);
        chk("s1_next_last", 64'(rlast), 64'd1);
        tick();
        chk("s1_rok_end", 64'(rok), 64'd0);

        // asynchronous reset in the middle of a word
        w     = 1'b1;
        wdata = {64'h73, 64'h72, 64'h71, 64'h70};
        wlen  = 2'd3;
        r     = 1'b1;
        tick();
        w = 1'b0;
        chk("ar_b0", rdata, 64'h70);
        tick();
        chk("ar_b1", rdata, 64'h71);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rok", 64'(rok), 64'd0);
        chk("ar_rdata", rdata, 64'd0);
        chk("ar_wok", 64'(wok), 64'd1);
        tick();
        rst_n = 1'b1;
        w     = 1'b1;
        wdata = {64'h83, 64'h82, 64'h81, 64'h80};
        wlen  = 2'd3;
        #1;
        chk("ar_idle_rok", 64'(rok), 64'd0);
        tick();
        w = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ar_new_data", rdata, 64'h80 + 64'(k));
            chk("ar_new_last", 64'(rlast), 64'(k == 3));
            tick();
        end
        chk("ar_rok_end", 64'(rok), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
